// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_BE_W    = 4;
    localparam int DMEM_LAT_MIN = 1;
    localparam int DMEM_LAT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState_t;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store request/response bundle.
// master = MEM stage, slave = dmem_responder.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [DMEM_BE_W-1:0]   req_be;
    logic [31:0]            req_addr;
    logic [DMEM_DATA_W-1:0] req_wdata;
    logic                   rsp_valid;
    logic [DMEM_DATA_W-1:0] rsp_rdata;
    logic                   rsp_err;
    logic                   stall;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with byte-enable write and registered read.
// Contents are not reset; rdata only changes on an enabled read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [DMEM_BE_W-1:0]   be,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write or full-word registered read when enabled
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < DMEM_BE_W; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned addresses are rejected
// with rsp_err instead of addressing the containing word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmemState_t             state;
    logic [3:0]             cnt;
    logic                   capWe;
    logic [DMEM_BE_W-1:0]   capBe;
    logic [31:0]            capAddr;
    logic [DMEM_DATA_W-1:0] capWdata;
    logic                   rspValid;
    logic                   rspErr;
    logic                   rspZero;
    logic                   reqReady;

    logic                   opWe;
    logic [DMEM_BE_W-1:0]   opBe;
    logic [31:0]            opAddr;
    logic [DMEM_DATA_W-1:0] opWdata;
    logic                   opErr;
    logic                   enterResp;
    logic                   memEn;
    logic [DMEM_DATA_W-1:0] memRdata;

`ifndef DMEM_ALIGN_CHECK_EN
    logic unusedAlign;
    assign unusedAlign = ^opAddr[1:0];
`endif

    // Operand select and RESP-entry decode; with LATENCY=1 the access
    // happens on the accept edge, so live bus inputs are used in IDLE.
    // Reset gates memEn so a store racing reset is never performed.
    always_comb begin
        if (state == IDLE) begin
            opWe    = bus.req_we;
            opBe    = bus.req_be;
            opAddr  = bus.req_addr;
            opWdata = bus.req_wdata;
        end else begin
            opWe    = capWe;
            opBe    = capBe;
            opAddr  = capAddr;
            opWdata = capWdata;
        end
        opErr = |opAddr[31:IDX_W+2];
`ifdef DMEM_ALIGN_CHECK_EN
        opErr = opErr | (|opAddr[1:0]);
`endif
        enterResp = 1'b0;
        case (state)
            IDLE:    enterResp = bus.req_valid && (LATENCY == 1);
            WAIT:    enterResp = (cnt == 4'd1);
            default: enterResp = 1'b0;
        endcase
        memEn = enterResp && reset && !opErr;
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            capWe    <= 1'b0;
            capBe    <= '0;
            capAddr  <= '0;
            capWdata <= '0;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspZero  <= 1'b1;
            reqReady <= 1'b1;
        end else begin
            rspValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        capWe    <= bus.req_we;
                        capBe    <= bus.req_be;
                        capAddr  <= bus.req_addr;
                        capWdata <= bus.req_wdata;
                        cnt      <= CNT_INIT;
                        reqReady <= 1'b0;
                        state    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
            endcase
            if (enterResp) begin
                rspValid <= 1'b1;
                rspErr   <= opErr;
                rspZero  <= opWe | opErr;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) uArray (
        .clk   (clk),
        .en    (memEn),
        .we    (opWe),
        .be    (opBe),
        .idx   (opAddr[IDX_W+1:2]),
        .wdata (opWdata),
        .rdata (memRdata)
    );

    assign bus.req_ready = reqReady;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_err   = rspErr;
    assign bus.rsp_rdata = rspZero ? '0 : memRdata;
    assign bus.stall     = ((state == IDLE) && bus.req_valid) || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance driven from a
// vector table, LATENCY=1 instance for back-to-back pacing.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dmem_responder_if ifA ();
    dmem_responder_if ifB ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dutA (
        .clk   (clk),
        .reset (rstA),
        .bus   (ifA)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dutB (
        .clk   (clk),
        .reset (rstB),
        .bus   (ifB)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request on instance A; reports what was seen at each negedge
    task automatic doReq(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                         output int stallCycles, output int respCycle,
                         output logic readyInResp, output logic seen);
        seen        = 1'b0;
        rd          = '0;
        er          = 1'b0;
        stallCycles = 0;
        respCycle   = 0;
        readyInResp = 1'b1;
        @(posedge clk); #1;
        ifA.req_valid = 1'b1;
        ifA.req_we    = we;
        ifA.req_be    = be;
        ifA.req_addr  = addr;
        ifA.req_wdata = wdata;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifA.stall) stallCycles++;
            if (ifA.rsp_valid) begin
                seen        = 1'b1;
                rd          = ifA.rsp_rdata;
                er          = ifA.rsp_err;
                respCycle   = i + 1;
                readyInResp = ifA.req_ready;
            end
            @(posedge clk); #1;
            ifA.req_valid = 1'b0;
            ifA.req_wdata = 32'hFFFF_FFFF;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          sc;
        int          rc;
        logic        rdy;
        logic        seen;
        logic        seenV;
        string       nm;

        vecs.push_back('{1'b1, 4'hF,    32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF,    32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 4'b0101, 32'h10,  32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'h0,    32'h10,  32'h0,        32'hDE22BE44, 1'b0});
        vecs.push_back('{1'b1, 4'hF,    32'h0,   32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 4'hF,    32'h400, 32'h55555555, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 4'hF,    32'h400, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 4'hF,    32'h0,   32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 4'hF,    32'h3FC, 32'h12345678, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF,    32'h3FC, 32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 4'h0,    32'h10,  32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF,    32'h10,  32'h0,        32'hDE22BE44, 1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
        vecs.push_back('{1'b0, 4'hF,    32'h13,  32'h0,        32'h0,        1'b1});
`else
        vecs.push_back('{1'b0, 4'hF,    32'h13,  32'h0,        32'hDE22BE44, 1'b0});
`endif
        vecs.push_back('{1'b1, 4'hF,    32'h20,  32'hA5A5A5A5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 4'hF,    32'hFFFFFFFC, 32'h0,   32'h0,        1'b1});

        ifA.req_valid = 1'b0; ifA.req_we = 1'b0; ifA.req_be = '0;
        ifA.req_addr  = '0;   ifA.req_wdata = '0;
        ifB.req_valid = 1'b0; ifB.req_we = 1'b0; ifB.req_be = '0;
        ifB.req_addr  = '0;   ifB.req_wdata = '0;
        rstA = 1'b0;
        rstB = 1'b0;

        // Reset state, stall follows req_valid while held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(ifA.rsp_valid), 32'd0);
        check("rst_rsp_rdata", ifA.rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(ifA.rsp_err), 32'd0);
        check("rst_req_ready", 32'(ifA.req_ready), 32'd1);
        check("rst_stall_lo",  32'(ifA.stall), 32'd0);
        ifA.req_valid = 1'b1;
        #1;
        check("rst_stall_hi",  32'(ifA.stall), 32'd1);
        ifA.req_valid = 1'b0;
        @(posedge clk); #1;
        rstA = 1'b1;
        rstB = 1'b1;

        // Table-driven requests on the LATENCY=2 instance
        for (int v = 0; v < vecs.size(); v++) begin
            doReq(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rd, er, sc, rc, rdy, seen);
            nm = $sformatf("v%0d", v);
            check({nm, "_rsp_seen"},  32'(seen), 32'd1);
            check({nm, "_rdata"},     rd, vecs[v].expRdata);
            check({nm, "_err"},       32'(er), 32'(vecs[v].expErr));
            check({nm, "_stall_cyc"}, 32'(sc), 32'd2);
            check({nm, "_rsp_cycle"}, 32'(rc), 32'd3);
            check({nm, "_ready_resp"}, 32'(rdy), 32'd0);
            @(negedge clk);
            check({nm, "_hold_rdata"}, ifA.rsp_rdata, vecs[v].expRdata);
            check({nm, "_hold_err"},   32'(ifA.rsp_err), 32'(vecs[v].expErr));
            check({nm, "_pulse_end"},  32'(ifA.rsp_valid), 32'd0);
        end

        // Reset during WAIT of a store: dropped, no response, no write
        @(posedge clk); #1;
        ifA.req_valid = 1'b1;
        ifA.req_we    = 1'b1;
        ifA.req_be    = 4'hF;
        ifA.req_addr  = 32'h20;
        ifA.req_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        ifA.req_valid = 1'b0;
        rstA = 1'b0;
        seenV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifA.rsp_valid) seenV = 1'b1;
        end
        check("rstmid_no_rsp", 32'(seenV), 32'd0);
        check("rstmid_ready",  32'(ifA.req_ready), 32'd1);
        @(posedge clk); #1;
        rstA = 1'b1;
        doReq(1'b0, 4'hF, 32'h20, 32'h0, rd, er, sc, rc, rdy, seen);
        check("rstmid_load_seen",  32'(seen), 32'd1);
        check("rstmid_load_rdata", rd, 32'hA5A5A5A5);
        check("rstmid_load_err",   32'(er), 32'd0);

        // LATENCY=1 with req_valid held: response every other cycle
        @(posedge clk); #1;
        ifB.req_valid = 1'b1;
        ifB.req_we    = 1'b1;
        ifB.req_be    = 4'hF;
        ifB.req_addr  = 32'h8;
        ifB.req_wdata = 32'h600DCAFE;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("l1_rsp_valid_%0d", k), 32'(ifB.rsp_valid), 32'(k % 2));
            check($sformatf("l1_ready_%0d", k),     32'(ifB.req_ready), 32'((k + 1) % 2));
            check($sformatf("l1_stall_%0d", k),     32'(ifB.stall),     32'((k + 1) % 2));
        end
        @(posedge clk); #1;
        ifB.req_we   = 1'b0;
        ifB.req_addr = 32'h8;
        @(negedge clk);
        check("l1_load_stall", 32'(ifB.stall), 32'd1);
        @(posedge clk); #1;
        ifB.req_valid = 1'b0;
        @(negedge clk);
        check("l1_load_valid", 32'(ifB.rsp_valid), 32'd1);
        check("l1_load_rdata", ifB.rsp_rdata, 32'h600DCAFE);
        check("l1_load_err",   32'(ifB.rsp_err), 32'd0);
        check("l1_load_stall_resp", 32'(ifB.stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
